// File: rtl/multiplier_arbiter_if.sv
// Streaming beat bundle (val/rdy handshake, sop/eop framing) shared by requesters,
// result consumers and the multiplier port of multiplier_arbiter.
interface multiplier_arbiter_if #(
  parameter int DAT_BITS = 381,
  parameter int CTL_BITS = 8,
  parameter int MOD_BITS = 6
);
  logic                  val;
  logic                  rdy;
  logic                  sop;
  logic                  eop;
  logic                  err;
  logic [2*DAT_BITS-1:0] dat;
  logic [CTL_BITS-1:0]   ctl;
  logic [MOD_BITS-1:0]   mod;

  modport source (output val, sop, eop, err, dat, ctl, mod, input rdy);
  modport sink   (input val, sop, eop, err, dat, ctl, mod, output rdy);
  modport master (output val, sop, eop, err, dat, ctl, mod, input rdy);
  modport slave  (input val, sop, eop, err, dat, ctl, mod, output rdy);
endinterface

// File: rtl/multiplier_arbiter.sv
// Packet-atomic round-robin share of one in-order multiplier; beats are tagged with the
// requester index and results steered back by tag. MUL_ARB_STATS_EN builds grant counters.
module multiplier_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DAT_BITS = 381,
  parameter int CTL_BITS = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  multiplier_arbiter_if.sink   i_req [NUM_REQ],
  multiplier_arbiter_if.source o_res [NUM_REQ],
  multiplier_arbiter_if.source o_mul,
  multiplier_arbiter_if.sink   i_mul,
  output logic [31:0]          o_grant_cnt [NUM_REQ]
);
  localparam int ID_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DW      = 2 * DAT_BITS;

  typedef enum logic {IDLE, LOCK} state_t;

  logic [NUM_REQ-1:0]  req_val;
  logic [NUM_REQ-1:0]  req_sop;
  logic [NUM_REQ-1:0]  req_eop;
  logic [DW-1:0]       req_dat [NUM_REQ];
  logic [CTL_BITS-1:0] req_ctl [NUM_REQ];
  logic [NUM_REQ-1:0]  res_rdy;
  logic [NUM_REQ-1:0]  unused_req;

  state_t              state_q, state_d;
  logic [ID_BITS-1:0]  owner_q, owner_d;
  logic [ID_BITS-1:0]  ptr_q, ptr_d;
  logic [ID_BITS-1:0]  grant, cand;
  logic                grant_vld;
  logic                ld, xfer;

  logic                vld_p0, sop_p0, eop_p0;
  logic [DW-1:0]       dat_p0;
  logic [CTL_BITS+ID_BITS-1:0] ctl_p0;

  logic [ID_BITS-1:0]  tag;
  logic                res_sel_rdy;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_port
    assign req_val[g]     = i_req[g].val;
    assign req_sop[g]     = i_req[g].sop;
    assign req_eop[g]     = i_req[g].eop;
    assign req_dat[g]     = i_req[g].dat;
    assign req_ctl[g]     = i_req[g].ctl;
    assign i_req[g].rdy   = ld & grant_vld & (grant == ID_BITS'(g));
    assign unused_req[g]  = ^{i_req[g].err, i_req[g].mod};

    assign o_res[g].val   = i_mul.val & (tag == ID_BITS'(g));
    assign o_res[g].dat   = i_mul.dat;
    assign o_res[g].ctl   = i_mul.ctl[CTL_BITS-1:0];
    assign o_res[g].sop   = i_mul.sop;
    assign o_res[g].eop   = i_mul.eop;
    assign o_res[g].err   = i_mul.err;
    assign o_res[g].mod   = i_mul.mod;
    assign res_rdy[g]     = o_res[g].rdy;
  end

  // Round-robin search from ptr+1; scanning backwards lets the nearest candidate win last.
  always_comb begin
    grant     = owner_q;
    grant_vld = 1'b0;
    cand      = '0;
    if (state_q == LOCK) begin
      grant_vld = 1'b1;
    end else begin
      for (int i = NUM_REQ; i >= 1; i--) begin
        cand = ID_BITS'((int'(ptr_q) + i) % NUM_REQ);
        if (req_val[cand]) begin
          grant     = cand;
          grant_vld = 1'b1;
        end
      end
    end
  end

  assign ld   = !vld_p0 | o_mul.rdy;
  assign xfer = ld & grant_vld & req_val[grant];

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      if (req_eop[grant]) begin
        state_d = IDLE;
        ptr_d   = grant;
      end else if (state_q == IDLE) begin
        if (req_sop[grant]) begin
          state_d = LOCK;
          owner_d = grant;
        end else begin
          ptr_d = grant;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= ID_BITS'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  // Stage p0: single output register toward the multiplier
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p0 <= 1'b0;
      sop_p0 <= 1'b0;
      eop_p0 <= 1'b0;
    end else if (ld) begin
      vld_p0 <= xfer;
      sop_p0 <= xfer & req_sop[grant];
      eop_p0 <= xfer & req_eop[grant];
    end
  end

  always_ff @(posedge i_clk) begin
    if (ld && xfer) begin
      dat_p0 <= req_dat[grant];
      ctl_p0 <= {grant, req_ctl[grant]};
    end
  end

  assign o_mul.val = vld_p0;
  assign o_mul.sop = sop_p0;
  assign o_mul.eop = eop_p0;
  assign o_mul.dat = dat_p0;
  assign o_mul.ctl = ctl_p0;
  assign o_mul.err = 1'b0;
  assign o_mul.mod = '0;

  // Return path: a stalled owner holds the multiplier; out-of-range tags are dropped.
  assign tag = i_mul.ctl[CTL_BITS +: ID_BITS];

  always_comb begin
    res_sel_rdy = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (tag == ID_BITS'(k)) res_sel_rdy = res_rdy[k];
    end
  end

  assign i_mul.rdy = !i_mul.val | res_sel_rdy;

`ifdef MUL_ARB_STATS_EN
  logic [31:0] cnt_q [NUM_REQ];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < NUM_REQ; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (xfer && (grant == ID_BITS'(k))) cnt_q[k] <= cnt_q[k] + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign o_grant_cnt[g] = cnt_q[g];
  end
`else
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign o_grant_cnt[g] = 32'd0;
  end
`endif

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Scoreboard bench for multiplier_arbiter: requester queues feed the DUT, expected beats
// are queued in predicted arbitration order and compared as o_mul / o_res hand them over.
module tb_multiplier_arbiter;
  localparam int NR = 4;
  localparam int DB = 16;
  localparam int CB = 8;

  typedef struct packed {
    logic [2*DB-1:0] dat;
    logic [CB-1:0]   ctl;
    logic            sop;
    logic            eop;
  } beat_t;

  typedef struct packed {
    logic [1:0] id;
    beat_t      b;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        mul_gate;
  logic [NR-1:0] res_rdy;
  logic [31:0] cnt [NR];

  beat_t rq [NR][$];
  exp_t  exp_mul [$];
  exp_t  exp_res [$];
  int    n_chk = 0;
  int    n_err = 0;
  int    mul_beats = 0;

  multiplier_arbiter_if #(.DAT_BITS(DB), .CTL_BITS(CB))     req_if [NR] ();
  multiplier_arbiter_if #(.DAT_BITS(DB), .CTL_BITS(CB))     res_if [NR] ();
  multiplier_arbiter_if #(.DAT_BITS(DB), .CTL_BITS(CB + 2)) mul_o ();
  multiplier_arbiter_if #(.DAT_BITS(DB), .CTL_BITS(CB + 2)) mul_i ();

  multiplier_arbiter #(.NUM_REQ(NR), .DAT_BITS(DB), .CTL_BITS(CB)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req_if),
    .o_res       (res_if),
    .o_mul       (mul_o),
    .i_mul       (mul_i),
    .o_grant_cnt (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mul_o.rdy = mul_gate;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic beat_t mk_beat(int k, int n, logic sop, logic eop);
    beat_t b;
    b.dat = 32'hA500_0000 ^ 32'(k * 32'h0011_0000) ^ 32'(n * 32'h0000_0101);
    b.ctl = 8'(k * 16 + n);
    b.sop = sop;
    b.eop = eop;
    return b;
  endfunction

  task automatic push_req(int k, int n, logic sop, logic eop);
    rq[k].push_back(mk_beat(k, n, sop, eop));
  endtask

  task automatic push_exp(int k, int n, logic sop, logic eop);
    exp_t e;
    e.id = 2'(k);
    e.b  = mk_beat(k, n, sop, eop);
    exp_mul.push_back(e);
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while ((exp_mul.size() != 0 || exp_res.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_mul_left"}, 64'(exp_mul.size()), 0);
    chk({tag, "_res_left"}, 64'(exp_res.size()), 0);
    repeat (2) @(negedge clk);
  endtask

  // Requester drivers and result monitors
  for (genvar k = 0; k < NR; k++) begin : g_drv
    logic  tx;
    int    stall_cnt = 0;
    beat_t cur;
    exp_t  re;

    initial begin
      tx = 1'b0;
      req_if[k].val = 1'b0;
      req_if[k].dat = '0;
      req_if[k].ctl = '0;
      req_if[k].sop = 1'b0;
      req_if[k].eop = 1'b0;
      req_if[k].err = 1'b0;
      req_if[k].mod = '0;
    end

    always @(posedge clk) begin
      tx = req_if[k].val & req_if[k].rdy & !rst;
      if (req_if[k].val & !req_if[k].rdy & !rst) stall_cnt++;
      #1;
      if (tx && rq[k].size() > 0) void'(rq[k].pop_front());
      if (rq[k].size() > 0) begin
        cur           = rq[k][0];
        req_if[k].val = 1'b1;
        req_if[k].dat = cur.dat;
        req_if[k].ctl = cur.ctl;
        req_if[k].sop = cur.sop;
        req_if[k].eop = cur.eop;
      end else begin
        req_if[k].val = 1'b0;
      end
    end

    assign res_if[k].rdy = res_rdy[k];

    always @(negedge clk) begin
      if (!rst && res_if[k].val && res_if[k].rdy) begin
        if (exp_res.size() == 0) begin
          chk("res_extra", 1, 0);
        end else begin
          re = exp_res.pop_front();
          chk("res_id",  64'(k), 64'(re.id));
          chk("res_ctl", 64'(res_if[k].ctl), 64'(re.b.ctl));
          chk("res_dat", 64'(res_if[k].dat), 64'(re.b.dat));
          chk("res_sopeop", {res_if[k].sop, res_if[k].eop}, {re.b.sop, re.b.eop});
        end
      end
    end
  end

  exp_t me;
  always @(negedge clk) begin
    if (!rst && mul_o.val && mul_o.rdy) begin
      mul_beats++;
      if (exp_mul.size() == 0) begin
        chk("mul_extra", 1, 0);
      end else begin
        me = exp_mul.pop_front();
        chk("mul_ctl", 64'(mul_o.ctl), 64'({me.id, me.b.ctl}));
        chk("mul_dat", 64'(mul_o.dat), 64'(me.b.dat));
        chk("mul_sopeop", {mul_o.sop, mul_o.eop}, {me.b.sop, me.b.eop});
        chk("mul_errmod", 64'({mul_o.err, mul_o.mod}), 0);
      end
    end
  end

  task automatic drive_mul(logic v, logic [1:0] id, logic [CB-1:0] c, logic [2*DB-1:0] d,
                           logic s, logic e);
    mul_i.val = v;
    mul_i.ctl = {id, c};
    mul_i.dat = d;
    mul_i.sop = s;
    mul_i.eop = e;
    mul_i.err = 1'b0;
    mul_i.mod = '0;
  endtask

  initial begin
    #300000;
    n_err++;
    $display("FAIL timeout: simulation did not finish");
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] held;
    exp_t        er;
    int          base, s0;

    rst      = 1'b1;
    mul_gate = 1'b1;
    res_rdy  = '1;
    drive_mul(1'b0, 2'd0, '0, '0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    chk("rst_mul_val", 64'(mul_o.val), 0);
    chk("rst_res0_val", 64'(res_if[0].val), 0);
    chk("rst_imul_rdy", 64'(mul_i.rdy), 1);
    for (int k = 0; k < NR; k++) chk("rst_cnt", 64'(cnt[k]), 0);

    // all requesters single-beat, round-robin from requester 0
    for (int r = 0; r < 2; r++) for (int k = 0; k < NR; k++) push_req(k, r, 1'b1, 1'b1);
    for (int r = 0; r < 2; r++) for (int k = 0; k < NR; k++) push_exp(k, r, 1'b1, 1'b1);
    @(negedge clk);
    #1 rst = 1'b0;
    chk("t1_val_at_release", 64'(mul_o.val), 0);
    @(negedge clk);
    chk("t1_first_val", 64'(mul_o.val), 1);
    chk("t1_first_tag", 64'(mul_o.ctl[CB+:2]), 0);
    #1 base = mul_beats;
    repeat (7) @(negedge clk);
    #1 chk("t1_full_rate", 64'(mul_beats - base), 7);
    drain("t1");

    // packet lock: req1 three beats ahead of a waiting req0
    push_req(0, 8, 1'b1, 1'b1);
    push_exp(0, 8, 1'b1, 1'b1);
    drain("t2a");
    s0 = g_drv[0].stall_cnt;
    push_req(1, 9, 1'b1, 1'b0);
    push_req(1, 10, 1'b0, 1'b0);
    push_req(1, 11, 1'b0, 1'b1);
    push_req(0, 12, 1'b1, 1'b1);
    push_exp(1, 9, 1'b1, 1'b0);
    push_exp(1, 10, 1'b0, 1'b0);
    push_exp(1, 11, 1'b0, 1'b1);
    push_exp(0, 12, 1'b1, 1'b1);
    drain("t2");
    chk("t2_req0_stall", 64'(g_drv[0].stall_cnt - s0), 3);

    // multiplier back-pressure mid-stream
    for (int i = 0; i < 4; i++) begin
      push_req(1, 20 + i, 1'b1, 1'b1);
      push_req(2, 24 + i, 1'b1, 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      push_exp(1, 20 + i, 1'b1, 1'b1);
      push_exp(2, 24 + i, 1'b1, 1'b1);
    end
    repeat (3) @(posedge clk);
    #2 mul_gate = 1'b0;
    @(negedge clk);
    chk("t3_stall_val", 64'(mul_o.val), 1);
    held = 64'({mul_o.ctl, mul_o.dat});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_hold", 64'({mul_o.ctl, mul_o.dat}), held);
      chk("t3_req_blocked", 64'(req_if[1].rdy | req_if[2].rdy), 0);
    end
    @(posedge clk);
    #2 mul_gate = 1'b1;
    drain("t3");

    // return path head-of-line blocking and tag stripping
    @(posedge clk);
    #1;
    res_rdy[2] = 1'b0;
    drive_mul(1'b1, 2'd2, 8'hA5, 32'h1234_5678, 1'b1, 1'b1);
    er.id = 2'd2; er.b = {32'h1234_5678, 8'hA5, 1'b1, 1'b1};
    exp_res.push_back(er);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_imul_rdy_stall", 64'(mul_i.rdy), 0);
      chk("t4_res2_val", 64'(res_if[2].val), 1);
      chk("t4_res0_val", 64'(res_if[0].val), 0);
    end
    @(posedge clk);
    #1 res_rdy[2] = 1'b1;
    @(negedge clk);
    chk("t4_imul_rdy_go", 64'(mul_i.rdy), 1);
    @(posedge clk);
    #1;
    drive_mul(1'b1, 2'd0, 8'h3C, 32'h9ABC_DEF0, 1'b1, 1'b0);
    er.id = 2'd0; er.b = {32'h9ABC_DEF0, 8'h3C, 1'b1, 1'b0};
    exp_res.push_back(er);
    @(negedge clk);
    chk("t4_res2_after", 64'(res_if[2].val), 0);
    @(posedge clk);
    #1 drive_mul(1'b0, 2'd0, '0, '0, 1'b0, 1'b0);
    drain("t4");
    chk("t4_idle_rdy", 64'(mul_i.rdy), 1);

    // reset while req3 holds the lock
    push_req(3, 40, 1'b1, 1'b0);
    push_req(3, 41, 1'b0, 1'b0);
    push_req(3, 42, 1'b0, 1'b0);
    push_req(3, 43, 1'b0, 1'b1);
    push_req(0, 44, 1'b1, 1'b1);
    push_exp(3, 40, 1'b1, 1'b0);
    push_exp(3, 41, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("t5_lock_blk_rdy", 64'(req_if[0].rdy), 0);
    chk("t5_lock_blk_val", 64'(req_if[0].val), 1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    rq[3].delete();
    @(negedge clk);
    chk("t5_rst_mul_val", 64'(mul_o.val), 0);
    push_req(3, 45, 1'b1, 1'b1);
    push_exp(0, 44, 1'b1, 1'b1);
    push_exp(3, 45, 1'b1, 1'b1);
    @(negedge clk);
    #1 rst = 1'b0;
    drain("t5");

    // grant counters from a fresh reset
    #1 rst = 1'b1;
    for (int i = 0; i < 10; i++) push_req(2, 50 + i, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) push_req(0, 60 + i, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      push_exp(0, 60 + i, 1'b1, 1'b1);
      push_exp(2, 50 + i, 1'b1, 1'b1);
    end
    for (int i = 3; i < 10; i++) push_exp(2, 50 + i, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    drain("t6");
`ifdef MUL_ARB_STATS_EN
    chk("t6_cnt0", 64'(cnt[0]), 3);
    chk("t6_cnt1", 64'(cnt[1]), 0);
    chk("t6_cnt2", 64'(cnt[2]), 10);
    chk("t6_cnt3", 64'(cnt[3]), 0);
`else
    for (int k = 0; k < NR; k++) chk("t6_cnt_off", 64'(cnt[k]), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
